// File: rtl/speed_test_sequencer_if.sv
// Result port of the speed-test sequencer: a valid/ready handshake carrying
// the two tick counts and the pass/fail flags.
//   res_valid  sequencer -> consumer  result available
//   res_ready  consumer  -> sequencer result consumed
//   ticks0/1   sequencer -> consumer  24'hFFFFFF - raw count of each ring
//   flags      sequencer -> consumer  {timeout, overflow, skew, too_small}
interface speed_test_sequencer_if;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] ticks0;
  logic [23:0] ticks1;
  logic [3:0]  flags;

  modport master (
    output res_valid,
    output ticks0,
    output ticks1,
    output flags,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  ticks0,
    input  ticks1,
    input  flags,
    output res_ready
  );
endinterface

// File: rtl/speed_test_sequencer.sv
// Controller for the ring-oscillator speed-test block. One start runs a full
// measurement: arm, trigger, settle, poll for the fired flag, read both 24-bit
// down-counters byte by byte, then compute tick counts and flags.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   start        measurement request, only looked at in IDLE
//   busy         high in every state except IDLE
//   st_nrst, st_trig, st_sel, st_ring_en   control outputs to the speed-test block
//   st_out       speed-test byte bus (bit 6 = fired when st_sel = 7)
//   res          result handshake (see speed_test_sequencer_if)
module speed_test_sequencer #(
  parameter int unsigned TRIG_CYCLES   = 2,
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter int unsigned TIMEOUT       = 64,
  parameter int unsigned MAX_SKEW      = 3,
  parameter int unsigned MIN_COUNT     = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          st_nrst,
  output logic                          st_trig,
  output logic [2:0]                    st_sel,
  output logic [1:0]                    st_ring_en,
  input  logic [7:0]                    st_out,
  speed_test_sequencer_if.master        res
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_TRIG, S_SETTLE, S_POLL, S_READ, S_CALC, S_DONE
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;        // cycle counter shared by TRIG, SETTLE and POLL
  logic [3:0]  read_cnt_q;   // 0..11 within READ; odd value = capture cycle
  logic [23:0] count0_q, count1_q;
  logic        timeout_q;

  logic        busy_q, st_nrst_q, st_trig_q, res_valid_q;
  logic [2:0]  st_sel_q;
  logic [1:0]  st_ring_en_q;
  logic [23:0] ticks0_q, ticks1_q;
  logic [3:0]  flags_q;

  // Result computation, consumed only in CALC.
  logic [23:0]        ticks0_d, ticks1_d;
  logic [3:0]         flags_d;
  logic signed [24:0] diff_d;
  logic [24:0]        mag_d;
  logic               overflow_d, skew_d, too_small_d;

  always_comb begin
    ticks0_d    = ~count0_q;
    ticks1_d    = ~count1_q;
    diff_d      = $signed({1'b0, count0_q}) - $signed({1'b0, count1_q});
    mag_d       = diff_d[24] ? 25'(-diff_d) : 25'(diff_d);
    overflow_d  = ~count0_q[23] | ~count1_q[23];
    skew_d      = mag_d > 25'(MAX_SKEW);
    too_small_d = (count0_q < 24'(MIN_COUNT)) | (count1_q < 24'(MIN_COUNT));
    // A timeout reports only itself; the forced counts would give noise.
    flags_d     = timeout_q ? 4'b1000 : {1'b0, overflow_d, skew_d, too_small_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      read_cnt_q   <= '0;
      count0_q     <= '0;
      count1_q     <= '0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
      st_nrst_q    <= 1'b0;
      st_trig_q    <= 1'b0;
      st_sel_q     <= '0;
      st_ring_en_q <= '0;
      res_valid_q  <= 1'b0;
      ticks0_q     <= '0;
      ticks1_q     <= '0;
      flags_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_ARM;
            busy_q       <= 1'b1;
            st_nrst_q    <= 1'b1;
            st_ring_en_q <= 2'b11;
            st_sel_q     <= 3'd0;
            timeout_q    <= 1'b0;
          end
        end
        S_ARM: begin
          state_q   <= S_TRIG;
          st_trig_q <= 1'b1;
          cnt_q     <= 8'd1;
        end
        S_TRIG: begin
          if (cnt_q == 8'(TRIG_CYCLES)) begin
            state_q   <= S_SETTLE;
            st_trig_q <= 1'b0;
            cnt_q     <= 8'd1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 8'(SETTLE_CYCLES)) begin
            state_q      <= S_POLL;
            st_ring_en_q <= 2'b00;
            st_sel_q     <= 3'd7;
            cnt_q        <= 8'd1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_POLL: begin
          // cnt_q == 1 is the settle cycle after switching st_sel to 7.
          if (cnt_q >= 8'd2 && st_out[6]) begin
            state_q    <= S_READ;
            st_sel_q   <= 3'd1;
            read_cnt_q <= 4'd0;
          end else if (cnt_q == 8'(TIMEOUT)) begin
            state_q   <= S_CALC;
            timeout_q <= 1'b1;
            count0_q  <= 24'hFFFFFF;
            count1_q  <= 24'hFFFFFF;
            st_sel_q  <= 3'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_READ: begin
          if (read_cnt_q[0]) begin
            case (st_sel_q)
              3'd1:    count0_q[7:0]   <= st_out;
              3'd2:    count0_q[15:8]  <= st_out;
              3'd3:    count0_q[23:16] <= st_out;
              3'd4:    count1_q[7:0]   <= st_out;
              3'd5:    count1_q[15:8]  <= st_out;
              3'd6:    count1_q[23:16] <= st_out;
              default: ;
            endcase
          end
          if (read_cnt_q == 4'd11) begin
            state_q  <= S_CALC;
            st_sel_q <= 3'd0;
          end else if (read_cnt_q[0]) begin
            st_sel_q <= st_sel_q + 3'd1;
          end
          read_cnt_q <= read_cnt_q + 4'd1;
        end
        S_CALC: begin
          state_q     <= S_DONE;
          ticks0_q    <= ticks0_d;
          ticks1_q    <= ticks1_d;
          flags_q     <= flags_d;
          res_valid_q <= 1'b1;
          st_nrst_q   <= 1'b0;
        end
        S_DONE: begin
          if (res.res_ready) begin
            state_q     <= S_IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign st_nrst       = st_nrst_q;
  assign st_trig       = st_trig_q;
  assign st_sel        = st_sel_q;
  assign st_ring_en    = st_ring_en_q;
  assign res.res_valid = res_valid_q;
  assign res.ticks0    = ticks0_q;
  assign res.ticks1    = ticks1_q;
  assign res.flags     = flags_q;

endmodule

// File: tb/tb_speed_test_sequencer.sv
// Directed bench for speed_test_sequencer with a behavioural model of the
// speed-test output bus (byte mux over two model counts plus a fired flag).
module tb_speed_test_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        busy, st_nrst, st_trig;
  logic [2:0]  st_sel;
  logic [1:0]  st_ring_en;
  logic [7:0]  st_out;

  logic [23:0] m_count0 = 24'h0;
  logic [23:0] m_count1 = 24'h0;
  logic        m_fired  = 1'b0;

  int checks = 0;
  int passes = 0;

  speed_test_sequencer_if res_if ();

  speed_test_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .st_nrst    (st_nrst),
    .st_trig    (st_trig),
    .st_sel     (st_sel),
    .st_ring_en (st_ring_en),
    .st_out     (st_out),
    .res        (res_if.master)
  );

  always #5 clk = ~clk;

  always_comb begin
    st_out = 8'h00;
    case (st_sel)
      3'd1: st_out = m_count0[7:0];
      3'd2: st_out = m_count0[15:8];
      3'd3: st_out = m_count0[23:16];
      3'd4: st_out = m_count1[7:0];
      3'd5: st_out = m_count1[15:8];
      3'd6: st_out = m_count1[23:16];
      3'd7: st_out = {1'b0, m_fired, 6'b0};
      default: st_out = 8'h00;
    endcase
  end

  // Pulses start from IDLE and returns the edge index (edge 0 = start sampled)
  // at which res_valid is first seen high, or -1 if it never rises.
  task automatic do_run(output int valid_edge);
    valid_edge = -1;
    start = 1'b1;
    for (int e = 0; e < 200 && valid_edge < 0; e++) begin
      @(posedge clk); #1;
      if (e == 0) start = 1'b0;
      if (res_if.res_valid) valid_edge = e;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (st_nrst !== 1'b0) $display("FAIL reset_st_nrst: got %b want 0", st_nrst); else passes++;
    checks++; if (st_trig !== 1'b0) $display("FAIL reset_st_trig: got %b want 0", st_trig); else passes++;
    checks++; if (st_sel !== 3'd0) $display("FAIL reset_st_sel: got %0d want 0", st_sel); else passes++;
    checks++; if (st_ring_en !== 2'b00) $display("FAIL reset_ring_en: got %b want 00", st_ring_en); else passes++;
    checks++; if (res_if.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_if.res_valid); else passes++;
    checks++; if (res_if.ticks0 !== 24'h0 || res_if.ticks1 !== 24'h0) $display("FAIL reset_ticks: got %h/%h want 0/0", res_if.ticks0, res_if.ticks1); else passes++;
    checks++; if (res_if.flags !== 4'b0) $display("FAIL reset_flags: got %b want 0000", res_if.flags); else passes++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL reset_start_ignored: busy got %b want 0", busy); else passes++;
    $display("reset: busy=%b st_nrst=%b res_valid=%b", busy, st_nrst, res_if.res_valid);
  endtask

  // Leaves the DUT in DONE with res_ready low.
  task automatic test_nominal;
    logic [2:0] exp_sel;
    m_count0 = 24'hFFFF00; m_count1 = 24'hFFFF02; m_fired = 1'b1;
    res_if.res_ready = 1'b0;
    start = 1'b1;
    for (int e = 0; e <= 21; e++) begin
      @(posedge clk); #1;
      if (e == 0) begin
        start = 1'b0;
        checks++; if (busy !== 1'b1 || st_nrst !== 1'b1 || st_ring_en !== 2'b11)
          $display("FAIL nom_arm: got busy=%b nrst=%b ring=%b want 1 1 11", busy, st_nrst, st_ring_en); else passes++;
      end
      if (e == 1 || e == 2) begin
        checks++; if (st_trig !== 1'b1) $display("FAIL nom_trig_e%0d: got %b want 1", e, st_trig); else passes++;
      end
      if (e == 3) begin
        checks++; if (st_trig !== 1'b0 || st_ring_en !== 2'b11) $display("FAIL nom_settle: got trig=%b ring=%b want 0 11", st_trig, st_ring_en); else passes++;
      end
      if (e == 6) begin
        checks++; if (st_ring_en !== 2'b00) $display("FAIL nom_poll_ring: got %b want 00", st_ring_en); else passes++;
      end
      if (e >= 6 && e <= 19) begin
        exp_sel = (e < 8) ? 3'd7 : 3'(1 + (e - 8) / 2);
        checks++; if (st_sel !== exp_sel) $display("FAIL nom_sel_e%0d: got %0d want %0d", e, st_sel, exp_sel); else passes++;
      end
      if (e == 20) begin
        checks++; if (res_if.res_valid !== 1'b0) $display("FAIL nom_valid_early: got %b want 0", res_if.res_valid); else passes++;
      end
      if (e == 21) begin
        checks++; if (res_if.res_valid !== 1'b1) $display("FAIL nom_valid_e21: got %b want 1", res_if.res_valid); else passes++;
      end
    end
    checks++; if (res_if.ticks0 !== 24'h0000FF) $display("FAIL nom_ticks0: got %h want 0000ff", res_if.ticks0); else passes++;
    checks++; if (res_if.ticks1 !== 24'h0000FD) $display("FAIL nom_ticks1: got %h want 0000fd", res_if.ticks1); else passes++;
    checks++; if (res_if.flags !== 4'b0000) $display("FAIL nom_flags: got %b want 0000", res_if.flags); else passes++;
    checks++; if (st_nrst !== 1'b0) $display("FAIL nom_done_nrst: got %b want 0", st_nrst); else passes++;
    $display("nominal: ticks0=%h ticks1=%h flags=%b", res_if.ticks0, res_if.ticks1, res_if.flags);
  endtask

  task automatic test_backpressure;
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (res_if.res_valid !== 1'b1 || busy !== 1'b1) $display("FAIL bp_hold_c%0d: got valid=%b busy=%b want 1 1", c, res_if.res_valid, busy); else passes++;
      checks++; if (res_if.ticks0 !== 24'h0000FF || res_if.ticks1 !== 24'h0000FD || res_if.flags !== 4'b0)
        $display("FAIL bp_stable_c%0d: got %h %h %b want 0000ff 0000fd 0000", c, res_if.ticks0, res_if.ticks1, res_if.flags); else passes++;
      checks++; if (st_nrst !== 1'b0 || st_ring_en !== 2'b00) $display("FAIL bp_no_arm_c%0d: got nrst=%b ring=%b want 0 00", c, st_nrst, st_ring_en); else passes++;
    end
    res_if.res_ready = 1'b1;
    @(posedge clk); #1;
    res_if.res_ready = 1'b0;
    checks++; if (res_if.res_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_handshake: got valid=%b busy=%b want 0 0", res_if.res_valid, busy); else passes++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || st_nrst !== 1'b0) $display("FAIL bp_idle_after: got busy=%b nrst=%b want 0 0", busy, st_nrst); else passes++;
    $display("backpressure: released, busy=%b", busy);
  endtask

  task automatic test_flags;
    logic [23:0] t_c0 [3];
    logic [23:0] t_c1 [3];
    logic [3:0]  t_fl [3];
    logic [23:0] t_tk [3];
    int ve;
    t_c0[0] = 24'hFFFF00; t_c1[0] = 24'hFFFF10; t_fl[0] = 4'b0010; t_tk[0] = 24'h0000FF;
    t_c0[1] = 24'h7FFFF0; t_c1[1] = 24'hFFFF02; t_fl[1] = 4'b0110; t_tk[1] = 24'h80000F;
    t_c0[2] = 24'h000005; t_c1[2] = 24'hFFFF02; t_fl[2] = 4'b0111; t_tk[2] = 24'hFFFFFA;
    m_fired = 1'b1;
    res_if.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_count0 = t_c0[i]; m_count1 = t_c1[i];
      do_run(ve);
      checks++; if (ve !== 21) $display("FAIL flags%0d_latency: got %0d want 21", i, ve); else passes++;
      checks++; if (res_if.flags !== t_fl[i]) $display("FAIL flags%0d_flags: got %b want %b", i, res_if.flags, t_fl[i]); else passes++;
      checks++; if (res_if.ticks0 !== t_tk[i]) $display("FAIL flags%0d_ticks0: got %h want %h", i, res_if.ticks0, t_tk[i]); else passes++;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || res_if.res_valid !== 1'b0) $display("FAIL flags%0d_ready_high: got busy=%b valid=%b want 0 0", i, busy, res_if.res_valid); else passes++;
      $display("flags run %0d: count0=%h count1=%h flags=%b", i, t_c0[i], t_c1[i], res_if.flags);
    end
  endtask

  task automatic test_reset_mid_read;
    logic found;
    int ve;
    m_count0 = 24'hFFFF00; m_count1 = 24'hFFFF02; m_fired = 1'b1;
    res_if.res_ready = 1'b1;
    found = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (st_sel == 3'd4) found = 1'b1;
    end
    checks++; if (!found) $display("FAIL midread_reach_sel4: got not reached want reached"); else passes++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0 || st_nrst !== 1'b0 || st_trig !== 1'b0 || st_sel !== 3'd0 || st_ring_en !== 2'b00)
      $display("FAIL midread_ctrl: got busy=%b nrst=%b trig=%b sel=%0d ring=%b want all 0", busy, st_nrst, st_trig, st_sel, st_ring_en); else passes++;
    checks++; if (res_if.res_valid !== 1'b0 || res_if.ticks0 !== 24'h0 || res_if.ticks1 !== 24'h0 || res_if.flags !== 4'b0)
      $display("FAIL midread_result: got valid=%b %h %h %b want 0 0 0 0", res_if.res_valid, res_if.ticks0, res_if.ticks1, res_if.flags); else passes++;
    m_count0 = 24'hFFFFF0; m_count1 = 24'hFFFFF1;
    do_run(ve);
    checks++; if (ve !== 21) $display("FAIL midread_rerun_latency: got %0d want 21", ve); else passes++;
    checks++; if (res_if.ticks0 !== 24'h00000F || res_if.ticks1 !== 24'h00000E || res_if.flags !== 4'b0)
      $display("FAIL midread_rerun_result: got %h %h %b want 00000f 00000e 0000", res_if.ticks0, res_if.ticks1, res_if.flags); else passes++;
    @(posedge clk); #1;
    $display("reset mid-read: rerun ticks0=%h ticks1=%h", res_if.ticks0, res_if.ticks1);
  endtask

  task automatic test_timeout;
    int ve;
    m_count0 = 24'h123456; m_count1 = 24'h654321; m_fired = 1'b0;
    res_if.res_ready = 1'b1;
    do_run(ve);
    checks++; if (ve !== 71) $display("FAIL timeout_latency: got %0d want 71", ve); else passes++;
    checks++; if (res_if.flags !== 4'b1000) $display("FAIL timeout_flags: got %b want 1000", res_if.flags); else passes++;
    checks++; if (res_if.ticks0 !== 24'h0 || res_if.ticks1 !== 24'h0) $display("FAIL timeout_ticks: got %h %h want 0 0", res_if.ticks0, res_if.ticks1); else passes++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL timeout_idle: got busy=%b want 0", busy); else passes++;
    $display("timeout: valid_edge=%0d flags=%b", ve, res_if.flags);
  endtask

  initial begin
    res_if.res_ready = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_flags();
    test_reset_mid_read();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
